inst_fetch_mem: RTL and testbench

Parametrised byte-addressed instruction memory with a request/valid fetch handshake. It has a byte write port for loading programs, and a byte-serial read FSM that assembles each instruction big-endian. It registers the instruction and its decoded fields (opcode/DR/SR1/SR2/imm5), and flags misaligned or out-of-range fetches. It sits between the PC/fetch stage and the decode/control unit.

---
 rtl/inst_mem_pkg.sv | 42 ++++
 rtl/inst_field_decode.sv | 23 ++
 rtl/inst_fetch_mem.sv | 153 +++++++++++++++
 tb/tb_inst_fetch_mem.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction fetch memory: FSM states,
// LC-3 instruction field positions and opcode values.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE,
        FAULT
    } state_t;

    // Field positions within the upper 16 bits of an instruction
    localparam int OPC_MSB = 15;
    localparam int OPC_W   = 4;
    localparam int DR_LSB  = 9;
    localparam int SR1_LSB = 6;
    localparam int SR2_LSB = 0;
    localparam int REG_W   = 3;
    localparam int IMM5_W  = 5;

    localparam logic [3:0] BR   = 4'b0000;
    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] LD   = 4'b0010;
    localparam logic [3:0] ST   = 4'b0011;
    localparam logic [3:0] JSR  = 4'b0100;
    localparam logic [3:0] AND  = 4'b0101;
    localparam logic [3:0] LDR  = 4'b0110;
    localparam logic [3:0] STR  = 4'b0111;
    localparam logic [3:0] RTI  = 4'b1000;
    localparam logic [3:0] NOT  = 4'b1001;
    localparam logic [3:0] LDI  = 4'b1010;
    localparam logic [3:0] STI  = 4'b1011;
    localparam logic [3:0] JMP  = 4'b1100;
    localparam logic [3:0] RES  = 4'b1101;
    localparam logic [3:0] LEA  = 4'b1110;
    localparam logic [3:0] TRAP = 4'b1111;

    function automatic int bytes_per_inst(input int inst_w);
        return inst_w / 8;
    endfunction

endpackage

// File: rtl/inst_field_decode.sv
// Combinational split of the upper 16 instruction bits into LC-3 fields.
module inst_field_decode
    import inst_mem_pkg::*;
(
    input  logic [15:0]       word,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  sr1,
    output logic [REG_W-1:0]  sr2,
    output logic [IMM5_W-1:0] imm5
);

    // Bit 5 is the register/immediate mode flag; consumers decode it from inst.
    logic unused_mode_bit;

    assign opcode          = word[OPC_MSB -: OPC_W];
    assign dr              = word[DR_LSB +: REG_W];
    assign sr1             = word[SR1_LSB +: REG_W];
    assign sr2             = word[SR2_LSB +: REG_W];
    assign imm5            = word[IMM5_W-1:0];
    assign unused_mode_bit = word[5];

endmodule

// File: rtl/inst_fetch_mem.sv
// Byte-addressed instruction memory with a byte-serial big-endian fetch FSM.
// Define INST_FETCH_MEM_FWD_EN to forward a same-cycle write into the byte being read.
module inst_fetch_mem
    import inst_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 16,
    parameter int INST_W      = 16,
    parameter     INIT_FILE   = "test/test1.txt"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              inst_valid,
    output logic              fault,
    output logic [INST_W-1:0] inst,
    output logic [OPC_W-1:0]  opcode,
    output logic [REG_W-1:0]  dr,
    output logic [REG_W-1:0]  sr1,
    output logic [REG_W-1:0]  sr2,
    output logic [IMM5_W-1:0] imm5
);

    localparam int BPI    = bytes_per_inst(INST_W);
    localparam int MEM_AW = $clog2(DEPTH_BYTES);
    localparam int CNT_W  = $clog2(BPI);

    logic [7:0] mem [DEPTH_BYTES];

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [INST_W-1:0] shift_q;
    logic [MEM_AW-1:0] rd_idx;
    logic [7:0]        rd_byte;
    logic              wr_in_range;
    logic              addr_misaligned;
    logic              addr_out_of_range;
    logic              last_byte;

    logic [OPC_W-1:0]  dec_opcode;
    logic [REG_W-1:0]  dec_dr, dec_sr1, dec_sr2;
    logic [IMM5_W-1:0] dec_imm5;

    // Widened by one bit so addresses near 2**ADDR_W cannot wrap into range.
    assign wr_in_range       = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH_BYTES);
    assign addr_misaligned   = |fetch_addr[CNT_W-1:0];
    assign addr_out_of_range = ({1'b0, fetch_addr} + (ADDR_W+1)'(BPI))
                               > (ADDR_W+1)'(DEPTH_BYTES);

    assign rd_idx      = base_q + MEM_AW'(cnt_q);
    assign last_byte   = cnt_q == CNT_W'(BPI - 1);
    assign fetch_ready = state_q == IDLE;

`ifdef INST_FETCH_MEM_FWD_EN
    assign rd_byte = (wr_en && wr_addr == ADDR_W'(rd_idx)) ? wr_data : mem[rd_idx];
`else
    assign rd_byte = mem[rd_idx];
`endif

    // NOTE: the array has no reset; program images must survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    inst_field_decode u_decode (
        .word   (shift_q[INST_W-1 -: 16]),
        .opcode (dec_opcode),
        .dr     (dec_dr),
        .sr1    (dec_sr1),
        .sr2    (dec_sr2),
        .imm5   (dec_imm5)
    );

    // NOTE: default assigned first so no path through the case leaves a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    state_d = (addr_misaligned || addr_out_of_range) ? FAULT : READ;
                end
            end
            READ:    if (last_byte) state_d = DONE;
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, which is what gives read-before-write on the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            inst       <= '0;
            opcode     <= '0;
            dr         <= '0;
            sr1        <= '0;
            sr2        <= '0;
            imm5       <= '0;
        end else begin
            state_q    <= state_d;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_req) begin
                        base_q <= fetch_addr[MEM_AW-1:0];
                        cnt_q  <= '0;
                    end
                end
                READ: begin
                    shift_q <= {shift_q[INST_W-9:0], rd_byte};
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    inst       <= shift_q;
                    opcode     <= dec_opcode;
                    dr         <= dec_dr;
                    sr1        <= dec_sr1;
                    sr2        <= dec_sr2;
                    imm5       <= dec_imm5;
                    inst_valid <= 1'b1;
                end
                FAULT: begin
                    inst       <= '0;
                    opcode     <= '0;
                    dr         <= '0;
                    sr1        <= '0;
                    sr2        <= '0;
                    imm5       <= '0;
                    inst_valid <= 1'b1;
                    fault      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Self-checking bench for inst_fetch_mem: 16-bit and 32-bit instances share the
// write port; a byte-array reference model supplies expected fetch results.
module tb_inst_fetch_mem;
    import inst_mem_pkg::*;

    localparam int DEPTH = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    logic        fetch_req, fetch_ready, inst_valid, fault;
    logic [15:0] fetch_addr, inst;
    logic [3:0]  opcode;
    logic [2:0]  dr, sr1, sr2;
    logic [4:0]  imm5;

    logic        w_fetch_req, w_fetch_ready, w_inst_valid, w_fault;
    logic [15:0] w_fetch_addr;
    logic [31:0] w_inst;
    logic [3:0]  w_opcode;
    logic [2:0]  w_dr, w_sr1, w_sr2;
    logic [4:0]  w_imm5;

    inst_fetch_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(16), .INST_W(16), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .inst_valid(inst_valid), .fault(fault), .inst(inst), .opcode(opcode),
        .dr(dr), .sr1(sr1), .sr2(sr2), .imm5(imm5)
    );

    inst_fetch_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(16), .INST_W(32), .INIT_FILE("")) dut32 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_ready(w_fetch_ready),
        .inst_valid(w_inst_valid), .fault(w_fault), .inst(w_inst), .opcode(w_opcode),
        .dr(w_dr), .sr1(w_sr1), .sr2(w_sr2), .imm5(w_imm5)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] model [DEPTH];

    typedef struct {
        int          addr;
        logic        exp_fault;
        logic [15:0] exp_inst;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_fault(input int a, input int bpi);
        return (a % bpi != 0) || (a + bpi > DEPTH);
    endfunction

    function automatic logic [31:0] model_word(input int a, input int bpi);
        logic [31:0] w = 0;
        for (int i = 0; i < bpi; i++) w = (w << 8) | 32'(model[a + i]);
        return w;
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 16'(a);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    // Accept a fetch on the 16-bit instance and count cycles until inst_valid.
    task automatic fetch16(input int a, output int lat);
        fetch_req  = 1'b1;
        fetch_addr = 16'(a);
        tick();
        fetch_req = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (inst_valid) break;
        end
    endtask

    task automatic fetch32(input int a, output int lat);
        w_fetch_req  = 1'b1;
        w_fetch_addr = 16'(a);
        tick();
        w_fetch_req = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (w_inst_valid) break;
        end
    endtask

    task automatic check_fields16(input string name, input logic [15:0] w);
        check({name, ".opcode"}, 32'(opcode), 32'(w >> 12));
        check({name, ".dr"},     32'(dr),     32'((w >> 9) & 16'h7));
        check({name, ".sr1"},    32'(sr1),    32'((w >> 6) & 16'h7));
        check({name, ".sr2"},    32'(sr2),    32'(w & 16'h7));
        check({name, ".imm5"},   32'(imm5),   32'(w & 16'h1F));
    endtask

    task automatic check_fetch16(input string name, input int a);
        int          lat;
        logic        f;
        logic [15:0] e;
        f = model_fault(a, 2);
        e = f ? 16'h0 : 16'(model_word(a, 2));
        fetch16(a, lat);
        check({name, ".lat"},   32'(lat),   f ? 32'd1 : 32'd3);
        check({name, ".fault"}, 32'(fault), 32'(f));
        check({name, ".inst"},  32'(inst),  32'(e));
        check_fields16(name, e);
        tick();
        check({name, ".pulse"}, 32'(inst_valid), 32'd0);
    endtask

    task automatic check_fetch32(input string name, input int a);
        int          lat;
        logic        f;
        logic [31:0] e;
        f = model_fault(a, 4);
        e = f ? 32'h0 : model_word(a, 4);
        fetch32(a, lat);
        check({name, ".lat"},    32'(lat),      f ? 32'd1 : 32'd5);
        check({name, ".fault"},  32'(w_fault),  32'(f));
        check({name, ".inst"},   w_inst,        e);
        check({name, ".opcode"}, 32'(w_opcode), e >> 28);
    endtask

    // Fetch addr a; write (wa, wd) in the cycle that reads the second byte.
    task automatic fetch_with_write(input int a, input int wa, input logic [7:0] wd,
                                    output logic [15:0] got, output int lat);
        fetch_req  = 1'b1;
        fetch_addr = 16'(a);
        tick();
        fetch_req = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_addr = 16'(wa);
        wr_data = wd;
        tick();
        wr_en = 1'b0;
        model[wa] = wd;
        lat = 2;
        while (lat < 20) begin
            tick();
            lat++;
            if (inst_valid) break;
        end
        got = inst;
    endtask

    initial begin
        int          lat, first, second, ready_alone, pulses;
        logic [15:0] got, inst1, inst2;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        fetch_req = 1'b0; fetch_addr = '0; w_fetch_req = 1'b0; w_fetch_addr = '0;
        tick();
        tick();
        check("rst.ready", 32'(fetch_ready), 32'd1);
        check("rst.valid", 32'(inst_valid),  32'd0);
        check("rst.fault", 32'(fault),       32'd0);
        check("rst.inst",  32'(inst),        32'd0);
        check("rst.inst32", w_inst,          32'd0);
        check_fields16("rst", 16'h0);
        rst_n = 1'b1;
        tick();

        wr(0, 8'h12); wr(1, 8'h83); wr(2, 8'h34); wr(3, 8'h56);
        wr(126, 8'hAB); wr(127, 8'hCD);
        wr(128, 8'h77);  // out of range; would alias to byte 0 if not dropped

        vecs[0] = '{0,      1'b0, 16'h1283};
        vecs[1] = '{3,      1'b1, 16'h0000};
        vecs[2] = '{126,    1'b0, 16'hABCD};
        vecs[3] = '{128,    1'b1, 16'h0000};
        vecs[4] = '{2,      1'b0, 16'h3456};
        vecs[5] = '{'hFFFE, 1'b1, 16'h0000};
        vecs[6] = '{'hFFFF, 1'b1, 16'h0000};
        vecs[7] = '{1,      1'b1, 16'h0000};

        for (int i = 0; i < 8; i++) begin
            fetch16(vecs[i].addr, lat);
            check($sformatf("vec%0d.lat", i),   32'(lat),   vecs[i].exp_fault ? 32'd1 : 32'd3);
            check($sformatf("vec%0d.fault", i), 32'(fault), 32'(vecs[i].exp_fault));
            check($sformatf("vec%0d.inst", i),  32'(inst),  32'(vecs[i].exp_inst));
            tick();
        end

        check_fetch16("add", 0);
        check("add.opc_is_add", 32'(opcode), 32'(ADD));
        check("add.dr1",  32'(dr),   32'd1);
        check("add.sr12", 32'(sr1),  32'd2);
        check("add.sr23", 32'(sr2),  32'd3);
        check("add.imm3", 32'(imm5), 32'd3);

        // Request held high: second fetch accepted in the IDLE cycle after DONE.
        fetch_req  = 1'b1;
        fetch_addr = 16'd0;
        tick();
        fetch_addr = 16'd2;
        first = -1; second = -1; ready_alone = 0;
        inst1 = '0; inst2 = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (fetch_ready && !inst_valid) ready_alone++;
            if (inst_valid) begin
                if (first < 0) begin
                    first = n;
                    inst1 = inst;
                end else begin
                    second = n;
                    inst2 = inst;
                    break;
                end
            end
        end
        fetch_req = 1'b0;
        check("b2b.first",  32'(first),          32'd3);
        check("b2b.gap",    32'(second - first), 32'd4);
        check("b2b.inst1",  32'(inst1),          32'h1283);
        check("b2b.inst2",  32'(inst2),          32'h3456);
        check("b2b.ready",  32'(ready_alone),    32'd0);
        tick();

        fetch_with_write(0, 1, 8'hFF, got, lat);
`ifdef INST_FETCH_MEM_FWD_EN
        check("rw_same.inst", 32'(got), 32'h12FF);
`else
        check("rw_same.inst", 32'(got), 32'h1283);
`endif
        check("rw_same.lat", 32'(lat), 32'd3);
        check("rw_same.mem", 32'(model_word(0, 2)), 32'h12FF);
        check_fetch16("rw_same.after", 0);
        wr(1, 8'h83);

        fetch_with_write(2, 2, 8'h99, got, lat);
        check("rw_prev.inst", 32'(got), 32'h3456);
        check_fetch16("rw_prev.after", 2);
        wr(2, 8'h34);

        // Reset while in READ aborts the fetch.
        fetch_req  = 1'b1;
        fetch_addr = 16'd2;
        tick();
        fetch_req = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst.ready", 32'(fetch_ready), 32'd1);
        check("midrst.valid", 32'(inst_valid),  32'd0);
        check("midrst.inst",  32'(inst),        32'd0);
        check("midrst.fault", 32'(fault),       32'd0);
        check_fields16("midrst", 16'h0);
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (inst_valid) pulses++;
        end
        check("midrst.no_valid", 32'(pulses), 32'd0);
        check_fetch16("midrst.refetch", 0);
        check("midrst.refetch_val", 32'(inst), 32'h1283);

        for (int a = 0; a < DEPTH; a++) wr(a, 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: wr(int'($urandom_range(0, 140)), 8'($urandom));
                1: check_fetch16($sformatf("rnd%0d", i), int'($urandom_range(0, 65535)));
                default: check_fetch16($sformatf("rnd%0d", i), int'($urandom_range(0, 131)));
            endcase
        end

        wr(4, 8'h5A); wr(5, 8'h00); wr(6, 8'h11); wr(7, 8'h22);
        check_fetch32("w32.a4", 4);
        check("w32.a4_val", w_inst, 32'h5A001122);
        check("w32.a4_opc", 32'(w_opcode), 32'(AND));
        check_fetch32("w32.a2", 2);
        check_fetch32("w32.a124", 124);
        check_fetch32("w32.a126", 126);
        check_fetch32("w32.a128", 128);
        for (int i = 0; i < 6; i++) begin
            check_fetch32($sformatf("w32.rnd%0d", i), int'($urandom_range(0, 33)) * 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
